// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response constants, FSM state types and burst address helpers.
// Burst types: BURST_FIXED/INCR/WRAP. Responses: RESP_OKAY/SLVERR/DECERR.
// axi_next_addr: address of the following beat for FIXED, INCR and WRAP bursts.
// axi_resp_merge: folds two responses, SLVERR taking priority over DECERR over OKAY.
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  // WRAP keeps the upper bits of the aligned (len+1)<<size block and lets the
  // incremented offset roll over inside it; callers only allow power-of-two lengths.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr, input logic [2:0] size,
                                                input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] incr, mask;
    incr = addr + (64'd1 << size);
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    return burst == BURST_FIXED ? addr : burst == BURST_WRAP ? (addr & ~mask) | (incr & mask) : incr;
  endfunction
  function automatic logic [1:0] axi_resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a == RESP_SLVERR || b == RESP_SLVERR) ? RESP_SLVERR :
           (a == RESP_DECERR || b == RESP_DECERR) ? RESP_DECERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: per-beat burst address register with FIXED/INCR/WRAP stepping.
// Ports: clk, rst (async, active-high); load latches load_addr/size/len/burst for a new burst;
// step advances to the next beat; addr is the current beat address, addr_next the one after it
// (wrapped inside the aligned block for WRAP bursts).
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [2:0]        load_size,
  input  logic [7:0]        load_len,
  input  logic [1:0]        load_burst,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_next
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;

  always_comb begin
    addr_next = ADDR_W'(axi_next_addr(64'(addr_q), size_q, len_q, burst_q));
    addr_d    = load ? load_addr : step ? addr_next : addr_q;
    size_d    = load ? load_size : size_q;
    len_d     = load ? load_len : len_q;
    burst_d   = load ? load_burst : burst_q;
    addr      = addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end
endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 burst slave RAM with independent write (AW/W/B) and read (AR/R) FSMs.
// Ports: clk, rst (async, active-high); AW s_aw*, W s_w*, B s_b*, AR s_ar*, R s_r* slave channels.
// Build option: define AXI_BURST_RAM_WRAP_EN to accept WRAP bursts; otherwise WRAP answers SLVERR.
// Read data is registered: the beat is fetched on the AR / R handshake, so a same-cycle write
// to that word is seen only by later beats and a stalled beat stays stable.
module axi_burst_ram
  import axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast
);
  localparam int STRB_W = DATA_W / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(BYTE_SHIFT);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
`ifdef AXI_BURST_RAM_WRAP_EN
  localparam bit WRAP_OK = 1'b1;
`else
  localparam bit WRAP_OK = 1'b0;
`endif

  function automatic logic cmd_bad(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    return size > MAX_SIZE || burst == 2'd3 ||
           (burst == BURST_WRAP && !(WRAP_OK && len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> BYTE_SHIFT) < DEPTH_A;
  endfunction
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> BYTE_SHIFT);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  // Holds the ready outputs low while rst is high and until the first edge after release.
  logic live_q;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic [1:0]        wresp_q, wresp_d;
  logic [ADDR_W-1:0] waddr, waddr_next_unused;
  logic [IDX_W-1:0]  w_idx;
  logic              aw_hs, w_hs, b_hs, w_last, w_we;

  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic              rerr_q, rerr_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] raddr_unused, raddr_next, r_faddr;
  logic [IDX_W-1:0]  r_idx;
  logic              ar_hs, r_hs, r_last, r_fetch, r_ferr;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_waddr (
    .clk(clk), .rst(rst), .load(aw_hs), .step(w_hs),
    .load_addr(s_awaddr), .load_size(s_awsize), .load_len(s_awlen), .load_burst(s_awburst),
    .addr(waddr), .addr_next(waddr_next_unused)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_raddr (
    .clk(clk), .rst(rst), .load(ar_hs), .step(r_hs),
    .load_addr(s_araddr), .load_size(s_arsize), .load_len(s_arlen), .load_burst(s_arburst),
    .addr(raddr_unused), .addr_next(raddr_next)
  );

  // Write FSM: next state.
  always_comb begin
    w_state_d = (w_state_q == W_IDLE && aw_hs) ? W_DATA :
                (w_state_q == W_DATA && w_hs && w_last) ? W_RESP :
                (w_state_q == W_RESP && b_hs) ? W_IDLE : w_state_q;
  end

  // Write FSM: outputs.
  always_comb begin
    s_awready = live_q && w_state_q == W_IDLE;
    s_wready  = w_state_q == W_DATA;
    s_bvalid  = w_state_q == W_RESP;
    s_bresp   = w_state_q == W_RESP ? wresp_q : RESP_OKAY;
    s_bid     = wid_q;
  end

  // Write datapath. The beat count alone ends the burst; a disagreeing wlast only taints bresp.
  always_comb begin
    aw_hs   = s_awvalid && s_awready;
    w_hs    = s_wvalid && s_wready;
    b_hs    = s_bvalid && s_bready;
    w_last  = wcnt_q == wlen_q;
    w_idx   = word_idx(waddr);
    w_we    = w_hs && !werr_q && in_range(waddr);
    wid_d   = aw_hs ? s_awid : wid_q;
    wlen_d  = aw_hs ? s_awlen : wlen_q;
    werr_d  = aw_hs ? cmd_bad(s_awsize, s_awlen, s_awburst) : werr_q;
    wcnt_d  = aw_hs ? 8'd0 : w_hs ? wcnt_q + 8'd1 : wcnt_q;
    wresp_d = aw_hs ? (cmd_bad(s_awsize, s_awlen, s_awburst) ? RESP_SLVERR : RESP_OKAY) :
              w_hs ? axi_resp_merge(axi_resp_merge(wresp_q, s_wlast != w_last ? RESP_SLVERR : RESP_OKAY),
                                    in_range(waddr) ? RESP_OKAY : RESP_DECERR) : wresp_q;
  end

  // Read FSM: next state.
  always_comb begin
    r_state_d = (r_state_q == R_IDLE && ar_hs) ? R_DATA :
                (r_state_q == R_DATA && r_hs && r_last) ? R_IDLE : r_state_q;
  end

  // Read FSM: outputs.
  always_comb begin
    s_arready = live_q && r_state_q == R_IDLE;
    s_rvalid  = r_state_q == R_DATA;
    s_rlast   = r_state_q == R_DATA && rcnt_q == rlen_q;
    s_rid     = rid_q;
    s_rdata   = rdata_q;
    s_rresp   = rresp_q;
  end

  // Read datapath: the next beat is fetched on the handshake that retires the current one.
  always_comb begin
    ar_hs   = s_arvalid && s_arready;
    r_hs    = s_rvalid && s_rready;
    r_last  = rcnt_q == rlen_q;
    r_fetch = ar_hs || (r_hs && !r_last);
    r_faddr = ar_hs ? s_araddr : raddr_next;
    r_ferr  = ar_hs ? cmd_bad(s_arsize, s_arlen, s_arburst) : rerr_q;
    r_idx   = word_idx(r_faddr);
    rid_d   = ar_hs ? s_arid : rid_q;
    rlen_d  = ar_hs ? s_arlen : rlen_q;
    rerr_d  = r_ferr;
    rcnt_d  = ar_hs ? 8'd0 : r_hs ? rcnt_q + 8'd1 : rcnt_q;
    rdata_d = !r_fetch ? rdata_q : (r_ferr || !in_range(r_faddr)) ? '0 : mem[r_idx];
    rresp_d = !r_fetch ? rresp_q : r_ferr ? RESP_SLVERR : in_range(r_faddr) ? RESP_OKAY : RESP_DECERR;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++)
      if (w_we && s_wstrb[i]) mem[w_idx][8*i +: 8] <= s_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wresp_q   <= wresp_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: directed self-checking bench for axi_burst_ram (default parameters).
module tb_axi_burst_ram;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [3:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;

  int asserts = 0;
  int errors = 0;
  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];

  axi_burst_ram dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read there too, so a valid/ready pair
  // seen at a falling edge completes its handshake on the following rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] strb, input bit bad_last,
                          output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(negedge clk);
    s_awvalid = 1; s_awid = 4'h3; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    n = 0;
    while (!s_awready && n < 50) begin @(negedge clk); n++; end
    asserts++;
    if (!s_awready) begin
      errors++; $display("FAIL aw_timeout: awready=%b required 1", s_awready);
      s_awvalid = 0; return;
    end
    @(negedge clk);
    s_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1; s_wdata = wbuf[i]; s_wstrb = strb;
      s_wlast = bad_last ? (i == 0) : (i == int'(len));
      n = 0;
      while (!s_wready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    s_wvalid = 0; s_wlast = 0; s_bready = 1;
    n = 0;
    while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
    asserts++;
    if (!s_bvalid) begin
      errors++; $display("FAIL b_timeout: bvalid=%b required 1", s_bvalid);
      s_bready = 0; return;
    end
    resp = s_bresp;
    asserts++;
    if (s_bid !== 4'h3) begin errors++; $display("FAIL bid: got %h required 3", s_bid); end
    @(negedge clk);
    s_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit toggle, output int nbeats);
    int n;
    bit phase, stalled;
    logic [63:0] held;
    nbeats = 0;
    @(negedge clk);
    s_arvalid = 1; s_arid = 4'h5; s_araddr = addr; s_arlen = len; s_arsize = 3'd3; s_arburst = burst;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    asserts++;
    if (!s_arready) begin
      errors++; $display("FAIL ar_timeout: arready=%b required 1", s_arready);
      s_arvalid = 0; return;
    end
    @(negedge clk);
    s_arvalid = 0;
    asserts++;
    if (s_rvalid !== 1'b1) begin errors++; $display("FAIL r_latency: rvalid=%b required 1", s_rvalid); end
    n = 0; phase = 0; stalled = 0; held = '0;
    while (nbeats <= int'(len) && n < 200) begin
      s_rready = toggle ? phase : 1'b1;
      if (s_rvalid && s_rready) begin
        rbuf[nbeats] = s_rdata; rrsp[nbeats] = s_rresp; rlst[nbeats] = s_rlast;
        asserts++;
        if (s_rid !== 4'h5) begin errors++; $display("FAIL rid: got %h required 5", s_rid); end
        nbeats++;
      end else if (s_rvalid) begin
        stalled = 1; held = s_rdata;
      end
      @(negedge clk);
      n++; phase = ~phase;
      if (stalled) begin
        asserts++;
        if (s_rdata !== held) begin errors++; $display("FAIL r_stall_stable: got %h required %h", s_rdata, held); end
        stalled = 0;
      end
    end
    s_rready = 0;
    asserts++;
    if (nbeats != int'(len) + 1 || s_rvalid !== 1'b0) begin
      errors++; $display("FAIL r_beats: got %0d beats rvalid=%b required %0d beats rvalid=0", nbeats, s_rvalid, int'(len) + 1);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_rready = 0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake: got %b required 000000", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast});
    end
    asserts++;
    if ({s_bresp, s_rresp, s_bid, s_rid} !== 12'h0) begin
      errors++; $display("FAIL reset_resp_id: got %h required 000", {s_bresp, s_rresp, s_bid, s_rid});
    end
    asserts++;
    if (s_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", s_rdata); end
    rst = 0;
    #1;
    asserts++;
    if (s_awready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: awready=%b required 0", s_awready); end
    @(negedge clk);
    asserts++;
    if ({s_awready, s_arready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_release: got %b required 11", {s_awready, s_arready});
    end
  endtask

  task automatic test_incr;
    logic [1:0] resp;
    int nb;
    for (int i = 0; i < 8; i++) wbuf[i] = 64'(i + 5);
    do_write(32'h0, 8'd7, 3'd3, 2'd1, 8'hFF, 0, resp);
    asserts++;
    if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", resp); end
    do_read(32'h0, 8'd7, 2'd1, 0, nb);
    for (int i = 0; i < 8; i++) begin
      asserts++;
      if (rbuf[i] !== 64'(i + 5) || rrsp[i] !== 2'b00 || rlst[i] !== (i == 7)) begin
        errors++; $display("FAIL incr_rbeat%0d: got %h/%b/%b required %h/00/%b", i, rbuf[i], rrsp[i], rlst[i], 64'(i + 5), i == 7);
      end
    end
  endtask

  task automatic test_concurrent;
    logic [1:0] resp;
    int nb;
    for (int i = 0; i < 8; i++) wbuf[i] = 64'(i + 13);
    fork
      do_write(32'h40, 8'd7, 3'd3, 2'd1, 8'hFF, 0, resp);
      do_read(32'h0, 8'd7, 2'd1, 0, nb);
    join
    asserts++;
    if (resp !== 2'b00) begin errors++; $display("FAIL conc_bresp: got %b required 00", resp); end
    for (int i = 0; i < 8; i++) begin
      asserts++;
      if (rbuf[i] !== 64'(i + 5)) begin errors++; $display("FAIL conc_read0_%0d: got %h required %h", i, rbuf[i], 64'(i + 5)); end
    end
    do_read(32'h40, 8'd7, 2'd1, 0, nb);
    for (int i = 0; i < 8; i++) begin
      asserts++;
      if (rbuf[i] !== 64'(i + 13)) begin errors++; $display("FAIL conc_read40_%0d: got %h required %h", i, rbuf[i], 64'(i + 13)); end
    end
  endtask

  task automatic test_wrap;
    logic [1:0] resp;
    int nb;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(32'hA0 + i);
    do_write(32'h18, 8'd3, 3'd3, 2'd2, 8'hFF, 0, resp);
`ifdef AXI_BURST_RAM_WRAP_EN
    asserts++;
    if (resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %b required 00", resp); end
    do_read(32'h0, 8'd3, 2'd1, 0, nb);
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if (rbuf[i] !== 64'(32'hA0 + ((i + 1) % 4))) begin
        errors++; $display("FAIL wrap_mem%0d: got %h required %h", i, rbuf[i], 64'(32'hA0 + ((i + 1) % 4)));
      end
    end
    do_read(32'h18, 8'd3, 2'd2, 0, nb);
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if (rbuf[i] !== 64'(32'hA0 + i) || rrsp[i] !== 2'b00) begin
        errors++; $display("FAIL wrap_read%0d: got %h/%b required %h/00", i, rbuf[i], rrsp[i], 64'(32'hA0 + i));
      end
    end
`else
    asserts++;
    if (resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got %b required 10", resp); end
    do_read(32'h0, 8'd3, 2'd1, 0, nb);
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if (rbuf[i] !== 64'(i + 5)) begin errors++; $display("FAIL wrap_unchanged%0d: got %h required %h", i, rbuf[i], 64'(i + 5)); end
    end
    do_read(32'h18, 8'd3, 2'd2, 0, nb);
    asserts++;
    if (rbuf[0] !== 64'h0 || rrsp[0] !== 2'b10) begin
      errors++; $display("FAIL wrap_read: got %h/%b required 0/10", rbuf[0], rrsp[0]);
    end
`endif
    do_read(32'h0, 8'd0, 2'd3, 0, nb);
    asserts++;
    if (rbuf[0] !== 64'h0 || rrsp[0] !== 2'b10 || rlst[0] !== 1'b1) begin
      errors++; $display("FAIL reserved_burst: got %h/%b/%b required 0/10/1", rbuf[0], rrsp[0], rlst[0]);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] resp;
    int nb;
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h100, 8'd0, 3'd3, 2'd1, 8'hFF, 0, resp);
    wbuf[0] = 64'h0;
    do_write(32'h100, 8'd0, 3'd3, 2'd1, 8'h0F, 0, resp);
    do_read(32'h100, 8'd0, 2'd1, 0, nb);
    asserts++;
    if (rbuf[0] !== 64'hFFFF_FFFF_0000_0000) begin
      errors++; $display("FAIL strobe: got %h required ffffffff00000000", rbuf[0]);
    end
    wbuf[0] = 64'h1234;
    do_write(32'h100, 8'd0, 3'd4, 2'd1, 8'hFF, 0, resp);
    asserts++;
    if (resp !== 2'b10) begin errors++; $display("FAIL size_bresp: got %b required 10", resp); end
    do_read(32'h100, 8'd0, 2'd1, 0, nb);
    asserts++;
    if (rbuf[0] !== 64'hFFFF_FFFF_0000_0000) begin
      errors++; $display("FAIL size_nowrite: got %h required ffffffff00000000", rbuf[0]);
    end
  endtask

  task automatic test_errors;
    logic [1:0] resp;
    int nb;
    wbuf[0] = 64'h33; wbuf[1] = 64'h44;
    do_write(32'h200, 8'd1, 3'd3, 2'd1, 8'hFF, 1, resp);
    asserts++;
    if (resp !== 2'b10) begin errors++; $display("FAIL wlast_bresp: got %b required 10", resp); end
    do_read(32'h200, 8'd1, 2'd1, 0, nb);
    asserts++;
    if (rbuf[0] !== 64'h33 || rbuf[1] !== 64'h44) begin
      errors++; $display("FAIL wlast_data: got %h %h required 33 44", rbuf[0], rbuf[1]);
    end
    wbuf[0] = 64'h11; wbuf[1] = 64'h22;
    do_write(32'h7F8, 8'd1, 3'd3, 2'd1, 8'hFF, 0, resp);
    asserts++;
    if (resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp: got %b required 11", resp); end
    do_read(32'h7F8, 8'd1, 2'd1, 1, nb);
    asserts++;
    if (rbuf[0] !== 64'h11 || rrsp[0] !== 2'b00 || rlst[0] !== 1'b0) begin
      errors++; $display("FAIL decerr_beat0: got %h/%b/%b required 11/00/0", rbuf[0], rrsp[0], rlst[0]);
    end
    asserts++;
    if (rbuf[1] !== 64'h0 || rrsp[1] !== 2'b11 || rlst[1] !== 1'b1) begin
      errors++; $display("FAIL decerr_beat1: got %h/%b/%b required 0/11/1", rbuf[1], rrsp[1], rlst[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp;
    int nb;
    @(negedge clk);
    s_awvalid = 1; s_awid = 4'h3; s_awaddr = 32'h300; s_awlen = 8'd7; s_awsize = 3'd3; s_awburst = 2'd1;
    @(negedge clk);
    s_awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      s_wvalid = 1; s_wdata = 64'(i + 100); s_wstrb = 8'hFF; s_wlast = 0;
      @(negedge clk);
    end
    rst = 1; s_wvalid = 0; s_bready = 1;
    #1;
    asserts++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b000) begin
      errors++; $display("FAIL midrst_outputs: got %b required 000", {s_bvalid, s_awready, s_wready});
    end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    asserts++;
    if ({s_bvalid, s_awready} !== 2'b01) begin
      errors++; $display("FAIL midrst_release: bvalid/awready got %b required 01", {s_bvalid, s_awready});
    end
    s_bready = 0;
    for (int i = 0; i < 8; i++) wbuf[i] = 64'(i + 200);
    do_write(32'h300, 8'd7, 3'd3, 2'd1, 8'hFF, 0, resp);
    asserts++;
    if (resp !== 2'b00) begin errors++; $display("FAIL midrst_next_bresp: got %b required 00", resp); end
    do_read(32'h300, 8'd7, 2'd1, 0, nb);
    asserts++;
    if (rbuf[3] !== 64'd203 || rbuf[7] !== 64'd207) begin
      errors++; $display("FAIL midrst_data: got %h %h required cb cf", rbuf[3], rbuf[7]);
    end
  endtask

  initial begin
    test_reset;
    test_incr;
    test_concurrent;
    test_wrap;
    test_strobe;
    test_errors;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end
endmodule
